// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Purpose:
//   Multi-cycle adder. Adds two WIDTH-bit operands plus a carry-in, DIGIT bits
//   per clock, with the carry kept in a register between steps. A request is
//   accepted on start and the result appears after STEPS = WIDTH/DIGIT run
//   cycles. Sum/Carry are registered and only change on the completion edge,
//   so they never show partial results.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 1)
//   DIGIT  bits added per clock; must divide WIDTH exactly
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, accepted in IDLE or DONE, ignored while busy
//   X      in   operand A, captured on accept
//   Y      in   operand B, captured on accept
//   Cin    in   carry-in, captured on accept
//   Sub    in   (only with SERIAL_ADDER_SUB_EN) 1 = compute X - Y - Cin
//   busy   out  high while the add is running
//   done   out  one-cycle pulse, Sum/Carry have just been updated
//   Sum    out  last completed result (modulo 2^WIDTH)
//   Carry  out  last completed carry-out of the MSB (1 = no borrow when
//               subtracting)
//
// Configuration macro:
//   SERIAL_ADDER_SUB_EN  adds the Sub port and subtract mode.
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cy_q, cy_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0]       b_load;
  logic                   cy_load;
  logic [DIGIT:0]         digit_sum;
  logic [WIDTH+DIGIT-1:0] res_shift;
  logic [WIDTH-1:0]       res_step;
  logic                   last_step;

  // Operand B / carry as loaded into the datapath. Subtraction is X + ~Y + ~Cin,
  // i.e. two's complement with the borrow-in folded into the initial carry.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load  = Sub ? ~Y   : Y;
  assign cy_load = Sub ? ~Cin : Cin;
`else
  assign b_load  = Y;
  assign cy_load = Cin;
`endif

  // One digit step: DIGIT-bit add with carry, DIGIT+1-bit result.
  assign digit_sum = {1'b0, a_q[DIGIT-1:0]}
                   + {1'b0, b_q[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, cy_q};

  // New digit enters at the MSB end; after STEPS steps the first digit has
  // travelled down to bit 0. Building the shift on a widened vector keeps it
  // valid for WIDTH == DIGIT, where the old result contributes nothing.
  assign res_shift = {digit_sum[DIGIT-1:0], res_q};
  assign res_step  = res_shift[WIDTH+DIGIT-1:DIGIT];

  assign last_step = (cnt_q == LAST_STEP);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = X;
          b_d     = b_load;
          cy_d    = cy_load;
          res_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        cy_d  = digit_sum[DIGIT];
        res_d = res_step;
        if (last_step) begin
          // Publish the complete result on the same edge as the final step.
          sum_d   = res_step;
          carry_d = digit_sum[DIGIT];
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        // Unreachable encoding: recover to IDLE without touching results.
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign Sum   = sum_q;
  assign Carry = carry_q;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Multi-cycle, parametrised successor to the 1-bit half adder.
- Adds two WIDTH-bit operands plus a carry-in, DIGIT bits per clock, with a registered carry between steps.
- Uses a start/busy/done handshake.
- Serves as the small-area arithmetic building block for the team's sequential datapath exercises.

Parameters:
- WIDTH, 8, operand and result width in bits; must be >= 1.
- DIGIT, 1, bits added per clock; must divide WIDTH exactly. STEPS = WIDTH/DIGIT.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on rising clk edges
- X  input  WIDTH  operand A; captured when start is accepted
- Y  input  WIDTH  operand B; captured when start is accepted
- Cin  input  1  carry-in; captured when start is accepted
- busy  output  1  high while the add is in progress (state RUN)
- done  output  1  one-cycle pulse: Sum and Carry just updated
- Sum  output  WIDTH  registered result; holds the last completed result
- Carry  output  1  registered carry-out of the MSB; holds the last completed result

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low.
- Reset (rst_n=0, at any time, including mid-operation):
  - state=IDLE; busy=0, done=0, Sum=0, Carry=0.
  - Internal shift registers, step counter and carry register cleared.
  - In-flight operation is discarded; no done pulse follows.
- States: IDLE, RUN, DONE.
- Accept: start=1 on an edge while state is IDLE or DONE.
  - Captures X, Y and Cin into internal registers; counter=0; state -> RUN.
  - busy=1 from this edge onward.
- start while in RUN: ignored. Captured operands are unaffected; X, Y and Cin may change freely.
- RUN, each edge:
  - Add the low DIGIT bits of the A and B shift registers plus the carry register (DIGIT+1-bit result).
  - Low DIGIT bits shift into the MSB end of the internal result register; the MSB becomes the new carry register value.
  - A and B shift right by DIGIT; counter increments.
- RUN, edge with counter == STEPS-1 (last step):
  - Full result copied to Sum and the final carry to Carry, on the same edge.
  - state -> DONE; busy=0; done=1.
- DONE:
  - Lasts exactly one cycle; done=0 on the next edge.
  - state -> IDLE, or -> RUN if start=1 (back-to-back, no bubble).
- Latency: done is high in the cycle following the STEPS-th edge after the accept edge. Throughput is one result per STEPS+1 cycles.
- Outputs:
  - Sum and Carry change only on the completion edge (or reset); they never show partial results.
  - Arithmetic is modulo 2^WIDTH; Carry = bit WIDTH of X+Y+Cin.
- WIDTH=DIGIT: STEPS=1, i.e. a single RUN cycle; the same handshake applies.
- start held high continuously: a new operation is accepted at every DONE, giving one done pulse per STEPS+1 cycles.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Extra port Sub, input, 1 bit, captured at accept together with the operands.
  - Sub=1: the captured B register is loaded with ~Y and the carry register with ~Cin, so the result is X - Y - Cin.
  - Carry=1 means no borrow.
  - Sub=0: behaviour identical to the undefined build.
- Undefined: no Sub port; addition only.

Test Plan:
- Wrap and carry-out, WIDTH=8, DIGIT=1: X=8'hFF, Y=8'h01, Cin=0, start for one cycle. Required: busy high for 8 cycles; done pulses once, 8 edges after accept; Sum=8'h00, Carry=1.
- Carry-in: X=8'h5A, Y=8'h33, Cin=1. Required: Sum=8'h8E, Carry=0. Previous Sum/Carry (8'h00/1) held unchanged until the done edge.
- Start during busy: second start with X=8'h01, Y=8'h01 issued 3 cycles into RUN of X=8'h10, Y=8'h20. Required: ignored; Sum=8'h30, exactly one done pulse.
- Reset mid-operation: rst_n low for 1 cycle, asynchronously, at RUN step 4. Required: busy, done, Sum and Carry all 0 immediately; no done pulse afterwards. A new start then completes normally.
- Digit and back-to-back, WIDTH=8, DIGIT=4, start held high:
  - X=8'hF0, Y=8'h10 -> done after 2 steps, Sum=8'h00, Carry=1.
  - Next operation, X=8'h0F, Y=8'h01, accepted in the DONE cycle -> Sum=8'h10, Carry=0.
- SERIAL_ADDER_SUB_EN, WIDTH=8, DIGIT=1, Sub=1, Cin=0:
  - X=8'h10, Y=8'h01 -> Sum=8'h0F, Carry=1.
  - X=8'h01, Y=8'h02 -> Sum=8'hFF, Carry=0.
